// File: rtl/cam_pkg.sv
// cam_pkg: shared pixel types, capture states and the RGB565 to RGB888 expansion
package cam_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  typedef enum logic [1:0] {SYNC_WAIT, VBLANK, ACTIVE, DROP} cap_state_e;
  typedef struct packed {
    rgb888_t pix;
    logic    sof;
    logic    eol;
  } pix_tag_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    return '{r: {p[15:11], p[15:13]}, g: {p[10:5], p[10:9]}, b: {p[4:0], p[4:2]}};
  endfunction
endpackage

// File: rtl/cam_pix_fifo.sv
// cam_pix_fifo: show-ahead pixel FIFO; a write into a full FIFO lands when a pop happens the same cycle
module cam_pix_fifo import cam_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  pix_tag_t wdata,
  input  logic     rd_en,
  output pix_tag_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  pix_tag_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rd    = rd_en & ~empty;
  assign wr    = wr_en & (~full | rd);
  assign rdata = mem_q[rp_q];
  always_comb begin
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= wdata;
endmodule

// File: rtl/cam_capture.sv
// cam_capture: camera RGB565 byte bus to tagged RGB888 valid/ready pixel stream
// CAM_TEST_PATTERN_EN replaces camera pixel data with 8 vertical colour bars
module cam_capture import cam_pkg::*; #(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cam_pclk_en,
  input  logic       i_cam_vsync,
  input  logic       i_cam_href,
  input  logic [7:0] i_cam_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_sof,
  output logic       o_eol,
  output logic       o_overflow,
  output logic       o_line_err
);
  localparam logic [15:0] H_MAX = 16'(H_ACTIVE);
  localparam logic [15:0] V_MAX = 16'(V_ACTIVE);
  cap_state_e state_q, state_d;
  logic vs_q, vs_d, hr_q, hr_d, phase_q, phase_d, sof_arm_q, sof_arm_d;
  logic ovf_q, ovf_d, lerr_q, lerr_d;
  logic [7:0] byte0_q, byte0_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic vs_rise, vs_fall, line_end, capture, wr_en, drop, pop, full, empty;
  pix_tag_t wdata, rdata;
  rgb888_t cam_pix;
  assign vs_rise  = i_cam_pclk_en & i_cam_vsync & ~vs_q;
  assign vs_fall  = i_cam_pclk_en & ~i_cam_vsync & vs_q;
  assign line_end = i_cam_pclk_en & ~i_cam_href & hr_q & (y_q < V_MAX);
  assign capture  = (state_q == ACTIVE) & i_cam_pclk_en & i_cam_href & (y_q < V_MAX);
  assign wr_en    = capture & phase_q & (x_q != H_MAX);
  assign pop      = ~empty & i_ready;
  assign drop     = wr_en & full & ~pop;
`ifdef CAM_TEST_PATTERN_EN
  assign cam_pix = '{r: {8{~x_q[8]}}, g: {8{~x_q[9]}}, b: {8{~x_q[7]}}};
`else
  assign cam_pix = rgb565_to_888({byte0_q, i_cam_data});
`endif
  assign wdata = '{pix: cam_pix, sof: sof_arm_q, eol: x_q == H_MAX - 16'd1};
  always_comb begin
    state_d   = state_q;
    vs_d      = i_cam_pclk_en ? i_cam_vsync : vs_q;
    hr_d      = i_cam_pclk_en ? i_cam_href : hr_q;
    phase_d   = capture ? ~phase_q : phase_q;
    byte0_d   = capture & ~phase_q ? i_cam_data : byte0_q;
    x_d       = capture & phase_q & (x_q != H_MAX) ? x_q + 16'd1 : x_q;
    y_d       = y_q;
    sof_arm_d = sof_arm_q & ~(wr_en & ~drop);
    ovf_d     = ovf_q | drop;
    lerr_d    = lerr_q;
    unique case (state_q)
      SYNC_WAIT: if (vs_rise) state_d = VBLANK;
      VBLANK: if (vs_fall) begin
        state_d   = ACTIVE;
        x_d       = '0;
        y_d       = '0;
        phase_d   = 1'b0;
        ovf_d     = 1'b0;
        lerr_d    = 1'b0;
        sof_arm_d = 1'b1;
      end
      ACTIVE: begin
        if (drop) state_d = DROP;
        if (line_end) begin
          lerr_d  = lerr_q | phase_q | (x_q != H_MAX);
          x_d     = '0;
          phase_d = 1'b0;
          y_d     = y_q + 16'd1;
        end
        // a line still open when the frame ends counts as incomplete
        if (vs_rise) begin
          state_d = VBLANK;
          lerr_d  = line_end ? lerr_d : lerr_q | phase_q | (x_q != '0);
          x_d     = '0;
          phase_d = 1'b0;
        end
      end
      DROP: if (vs_rise) state_d = VBLANK;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= SYNC_WAIT;
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      phase_q   <= 1'b0;
      sof_arm_q <= 1'b0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
      byte0_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_d;
      hr_q      <= hr_d;
      phase_q   <= phase_d;
      sof_arm_q <= sof_arm_d;
      ovf_q     <= ovf_d;
      lerr_q    <= lerr_d;
      byte0_q   <= byte0_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end
  cam_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .wr_en(wr_en),
    .wdata(wdata),
    .rd_en(i_ready),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );
  // head memory is not reset, so pixel fields are forced to zero while empty
  assign o_valid    = ~empty;
  assign o_red      = rdata.pix.r & {8{o_valid}};
  assign o_green    = rdata.pix.g & {8{o_valid}};
  assign o_blue     = rdata.pix.b & {8{o_valid}};
  assign o_sof      = rdata.sof & o_valid;
  assign o_eol      = rdata.eol & o_valid;
  assign o_overflow = ovf_q;
  assign o_line_err = lerr_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed checks of capture, colour expansion, backpressure, line errors and reset
module tb_cam_capture;
`ifdef CAM_TEST_PATTERN_EN
  localparam int H = 1024;
`else
  localparam int H = 4;
`endif
  logic clk = 0, rst = 1, en = 0, vs = 0, hr = 0, rdy = 1;
  logic [7:0] d = 0;
  logic valid, sof, eol, ovf, lerr;
  logic [7:0] r, g, b;
  int errs = 0, checks = 0;
  logic [23:0] q_pix[$];
  logic q_sof[$], q_eol[$];

  always #5 clk = ~clk;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_cam_pclk_en(en), .i_cam_vsync(vs), .i_cam_href(hr),
    .i_cam_data(d), .o_valid(valid), .i_ready(rdy), .o_red(r), .o_green(g), .o_blue(b),
    .o_sof(sof), .o_eol(eol), .o_overflow(ovf), .o_line_err(lerr)
  );

  always @(negedge clk) if (valid && rdy) begin
    q_pix.push_back({r, g, b});
    q_sof.push_back(sof);
    q_eol.push_back(eol);
  end

  task automatic send_byte(input logic v, input logic h, input logic [7:0] dat);
    @(posedge clk); #1 en = 1; vs = v; hr = h; d = dat;
    @(posedge clk); #1 en = 0;
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(0, 1, p[15:8]);
    send_byte(0, 1, p[7:0]);
  endtask

  task automatic end_line();
    send_byte(0, 0, 8'h00);
  endtask

  task automatic vsync_pulse();
    send_byte(1, 0, 8'h00);
    send_byte(1, 0, 8'h00);
    send_byte(0, 0, 8'h00);
    send_byte(0, 0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_pix.delete();
    q_sof.delete();
    q_eol.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid, r, g, b, sof, eol} !== 29'd0)
      $display("FAIL reset_out: got %h exp 0", {valid, r, g, b, sof, eol});
    checks++;
    if ({ovf, lerr} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {ovf, lerr});
    if ({valid, r, g, b, sof, eol} !== 29'd0 || {ovf, lerr} !== 2'b00) errs++;
    rst = 0;
    idle(2);
  endtask

  task automatic test_basic();
    clear_q();
    rdy = 1;
    vsync_pulse();
    repeat (2) begin
      repeat (4) send_pix(16'hF800);
      end_line();
    end
    idle(4);
    checks++;
    if (q_pix.size() != 8) begin errs++; $display("FAIL basic_count: got %0d exp 8", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 8; i++) begin
      checks++;
      if (q_pix[i] !== 24'hFF0000 || q_sof[i] !== (i == 0) || q_eol[i] !== (i % 4 == 3)) begin
        errs++;
        $display("FAIL basic_pix%0d: got %h sof=%b eol=%b exp ff0000 sof=%b eol=%b",
                 i, q_pix[i], q_sof[i], q_eol[i], i == 0, i % 4 == 3);
      end
    end
    checks++;
    if ({ovf, lerr} !== 2'b00) begin errs++; $display("FAIL basic_flags: got %b exp 00", {ovf, lerr}); end
  endtask

  task automatic test_colour();
    logic [23:0] exp_pix[4] = '{24'h00FF00, 24'h0000FF, 24'h848284, 24'hFF0000};
    clear_q();
    vsync_pulse();
    send_pix(16'h07E0);
    send_pix(16'h001F);
    send_pix(16'h8410);
    send_pix(16'hF800);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 4) begin errs++; $display("FAIL colour_count: got %0d exp 4", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 4; i++) begin
      checks++;
      if (q_pix[i] !== exp_pix[i]) begin
        errs++;
        $display("FAIL colour_pix%0d: got %h exp %h", i, q_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (lerr !== 1'b0) begin errs++; $display("FAIL colour_lerr: got %b exp 0", lerr); end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_pix[4] = '{24'h00FF00, 24'h0000FF, 24'h848284, 24'hFF0000};
    clear_q();
    rdy = 0;
    vsync_pulse();
    send_pix(16'h07E0);
    send_pix(16'h001F);
    send_pix(16'h8410);
    send_pix(16'hF800);
    end_line();
    send_pix(16'hF800);
    send_pix(16'hF800);
    end_line();
    idle(2);
    checks++;
    if (ovf !== 1'b1 || valid !== 1'b1) begin
      errs++;
      $display("FAIL bp_overflow: got ovf=%b valid=%b exp ovf=1 valid=1", ovf, valid);
    end
    rdy = 1;
    idle(8);
    checks++;
    if (q_pix.size() != 4) begin errs++; $display("FAIL bp_drain_count: got %0d exp 4", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 4; i++) begin
      checks++;
      if (q_pix[i] !== exp_pix[i]) begin
        errs++;
        $display("FAIL bp_pix%0d: got %h exp %h", i, q_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (ovf !== 1'b1) begin errs++; $display("FAIL bp_sticky: got %b exp 1", ovf); end
    vsync_pulse();
    checks++;
    if (ovf !== 1'b0) begin errs++; $display("FAIL bp_clear: got %b exp 0", ovf); end
  endtask

  task automatic test_bad_line();
    clear_q();
    rdy = 1;
    repeat (3) send_pix(16'hF800);
    send_byte(0, 1, 8'h07);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 3) begin errs++; $display("FAIL bad_count: got %0d exp 3", q_pix.size()); end
    for (int i = 0; i < q_eol.size(); i++) begin
      checks++;
      if (q_eol[i] !== 1'b0) begin errs++; $display("FAIL bad_eol%0d: got %b exp 0", i, q_eol[i]); end
    end
    checks++;
    if (lerr !== 1'b1) begin errs++; $display("FAIL bad_lerr: got %b exp 1", lerr); end
    clear_q();
    repeat (4) send_pix(16'h001F);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 4) begin errs++; $display("FAIL next_count: got %0d exp 4", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 4; i++) begin
      checks++;
      if (q_pix[i] !== 24'h0000FF || q_eol[i] !== (i == 3) || q_sof[i] !== 1'b0) begin
        errs++;
        $display("FAIL next_pix%0d: got %h eol=%b sof=%b exp 0000ff eol=%b sof=0",
                 i, q_pix[i], q_eol[i], q_sof[i], i == 3);
      end
    end
    checks++;
    if (lerr !== 1'b1) begin errs++; $display("FAIL bad_sticky: got %b exp 1", lerr); end
  endtask

  task automatic test_reset_midline();
    rdy = 0;
    vsync_pulse();
    repeat (3) send_pix(16'hF800);
    send_byte(0, 1, 8'hF8);
    end_line();
    send_pix(16'hF800);
    send_byte(0, 1, 8'hF8);
    checks++;
    if (valid !== 1'b1 || lerr !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst: got valid=%b lerr=%b exp 1 1", valid, lerr);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    checks++;
    if ({valid, r, g, b, sof, eol, ovf, lerr} !== 31'd0) begin
      errs++;
      $display("FAIL rst_mid_out: got %h exp 0", {valid, r, g, b, sof, eol, ovf, lerr});
    end
    clear_q();
    rdy = 1;
    send_byte(0, 1, 8'h00);
    repeat (3) send_pix(16'hF800);
    end_line();
    repeat (4) send_pix(16'hF800);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 0) begin errs++; $display("FAIL rst_no_vsync: got %0d pixels exp 0", q_pix.size()); end
    vsync_pulse();
    repeat (4) send_pix(16'h07E0);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 4) begin errs++; $display("FAIL rst_after_count: got %0d exp 4", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 4; i++) begin
      checks++;
      if (q_pix[i] !== 24'h00FF00 || q_sof[i] !== (i == 0)) begin
        errs++;
        $display("FAIL rst_after_pix%0d: got %h sof=%b exp 00ff00 sof=%b", i, q_pix[i], q_sof[i], i == 0);
      end
    end
  endtask

  task automatic test_pattern();
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    clear_q();
    rdy = 1;
    vsync_pulse();
    repeat (1024) send_pix(16'h1234);
    end_line();
    idle(4);
    checks++;
    if (q_pix.size() != 1024) begin errs++; $display("FAIL tp_count: got %0d exp 1024", q_pix.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q_pix[k*128] !== bars[k]) begin
        errs++;
        $display("FAIL tp_bar%0d: got %h exp %h", k, q_pix[k*128], bars[k]);
      end
    end
    checks++;
    if (q_pix[1023] !== 24'h000000 || q_eol[1023] !== 1'b1) begin
      errs++;
      $display("FAIL tp_last: got %h eol=%b exp 000000 eol=1", q_pix[1023], q_eol[1023]);
    end
  endtask

  initial begin
    test_reset();
`ifdef CAM_TEST_PATTERN_EN
    test_pattern();
`else
    test_basic();
    test_colour();
    test_backpressure();
    test_bad_line();
    test_reset_midline();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
